// File: rtl/sum_accum_pkg.sv
// Shared constants and state encoding for the sum_accum kernel.
package sum_accum_pkg;

  localparam int unsigned DataWDefault = 32;

  typedef enum logic [1:0] {
    StInit  = 2'd0,
    StCheck = 2'd1,
    StBody  = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/sum_accum.sv
// Sequential kernel computing s = 1 + 2 + ... + n, one addition per two cycles.
// Launches on every release of reset and holds the result until the next reset.
// Optional macro SUM_ACCUM_DONE_EN adds a sticky 'done' output.
module sum_accum
  import sum_accum_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] n,
`ifdef SUM_ACCUM_DONE_EN
  output logic [DATA_W-1:0] return_val,
  output logic              done
`else
  output logic [DATA_W-1:0] return_val
`endif
);

  localparam logic [DATA_W:0] IOne = {{DATA_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [DATA_W-1:0] n_q, n_d;
  logic [DATA_W:0]   i_q, i_d;      // one extra bit so i can pass the largest n
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] ret_q, ret_d;
  logic              loop_cont;

  // Signed compare at DATA_W+1 bits guarantees termination even for n = max positive.
  assign loop_cont = $signed(i_q) <= $signed({n_q[DATA_W-1], n_q});

  // Next-state and datapath updates; every register holds unless its state acts on it.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    acc_d   = acc_q;
    ret_d   = ret_q;
    unique case (state_q)
      StInit: begin
        n_d     = n;
        i_d     = IOne;
        acc_d   = '0;
        state_d = StCheck;
      end
      StCheck: begin
        if (loop_cont) begin
          state_d = StBody;
        end else begin
          ret_d   = acc_q;
          state_d = StDone;
        end
      end
      StBody: begin
        acc_d   = acc_q + i_q[DATA_W-1:0];
        i_d     = i_q + IOne;
        state_d = StCheck;
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= StInit;
      n_q     <= '0;
      i_q     <= '0;
      acc_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      acc_q   <= acc_d;
      ret_q   <= ret_d;
    end
  end

  assign return_val = ret_q;

`ifdef SUM_ACCUM_DONE_EN
  // StDone is only entered on the edge that loads return_val, so this tracks it exactly.
  assign done = (state_q == StDone);
`endif

endmodule

// File: tb/tb_sum_accum.sv
// Scoreboard bench for sum_accum: a 32-bit instance and an 8-bit instance (cheap wrap tests).
module tb_sum_accum;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [31:0] n;
  logic [31:0] rv;
  logic [7:0]  n8;
  logic [7:0]  rv8;
`ifdef SUM_ACCUM_DONE_EN
  logic        done;
  logic        done8;
`endif

  always #5 sys_clk = ~sys_clk;

  sum_accum #(.DATA_W(32)) dut32 (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .n          (n),
`ifdef SUM_ACCUM_DONE_EN
    .return_val (rv),
    .done       (done)
`else
    .return_val (rv)
`endif
  );

  sum_accum #(.DATA_W(8)) dut8 (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .n          (n8),
`ifdef SUM_ACCUM_DONE_EN
    .return_val (rv8),
    .done       (done8)
`else
    .return_val (rv8)
`endif
  );

  typedef struct {
    int          sel;   // 0: 32-bit instance, 1: 8-bit instance
    logic [31:0] exp;
    int          lat;
    int          hold;
  } item_t;

  item_t sb[$];
  int    total    = 0;
  int    bad      = 0;
  int    done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: counts edges since release and checks the expected item at the front of the queue.
  initial begin : monitor
    int          edges;
    logic        r;
    item_t       it;
    logic [31:0] act;
    logic        dact;
    edges = 0;
    forever begin
      @(posedge sys_clk);
      r = sys_rst_n;
      edges = r ? edges + 1 : 0;
      #1;
      if (!r) begin
        check("reset_rv32", rv, 32'd0);
        check("reset_rv8", {24'd0, rv8}, 32'd0);
`ifdef SUM_ACCUM_DONE_EN
        check("reset_done32", {31'd0, done}, 32'd0);
        check("reset_done8", {31'd0, done8}, 32'd0);
`endif
      end else if (sb.size() > 0) begin
        it   = sb[0];
        act  = (it.sel != 0) ? {24'd0, rv8} : rv;
        dact = 1'b0;
`ifdef SUM_ACCUM_DONE_EN
        dact = (it.sel != 0) ? done8 : done;
`endif
        if (edges < it.lat) begin
          check("early_zero", act, 32'd0);
`ifdef SUM_ACCUM_DONE_EN
          check("early_done", {31'd0, dact}, 32'd0);
`endif
        end else if (edges == it.lat) begin
          check("final", act, it.exp);
`ifdef SUM_ACCUM_DONE_EN
          check("final_done", {31'd0, dact}, 32'd1);
`endif
        end else if (edges == it.lat + it.hold) begin
          check("hold", act, it.exp);
`ifdef SUM_ACCUM_DONE_EN
          check("hold_done", {31'd0, dact}, 32'd1);
`endif
          void'(sb.pop_front());
          done_cnt++;
        end
      end
    end
  end

  // One launch: optional abort after abort_at edges, optional change of n after chg_at edges.
  task automatic run_case(input int sel, input logic [31:0] nv, input logic [7:0] nv8,
                          input logic [31:0] exp, input int lat, input int hold,
                          input int abort_at, input int chg_at, input logic [31:0] n_after);
    item_t it;
    int    start;
    @(negedge sys_clk);
    n = nv;
    n8 = nv8;
    sys_rst_n = 1'b0;
    if (abort_at > 0) begin
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (abort_at) @(negedge sys_clk);
      sys_rst_n = 1'b0;
      n = n_after;
    end
    it.sel = sel;
    it.exp = exp;
    it.lat = lat;
    it.hold = hold;
    start = done_cnt;
    sb.push_back(it);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    if (chg_at > 0) begin
      repeat (chg_at) @(negedge sys_clk);
      n = n_after;
    end
    for (int k = 0; k < lat + hold + 20 && done_cnt == start; k++) @(negedge sys_clk);
    if (done_cnt == start) begin
      total++;
      bad++;
      $display("FAIL timeout actual=no_result required=result_at_edge_%0d", lat);
      sb.delete();
    end
  endtask

  initial begin : stim
    sys_rst_n = 1'b0;
    n = '0;
    n8 = '0;
    repeat (2) @(negedge sys_clk);
    //        sel n              n8     exp         lat  hold abort chg n_after
    run_case(0, 32'd10,         8'd0,  32'd55,     22,  500, 0,    0,  32'd10);
    run_case(0, 32'd0,          8'd0,  32'd0,      2,   3,   0,    0,  32'd0);
    run_case(0, -32'sd5,        8'd0,  32'd0,      2,   3,   0,    0,  -32'sd5);
    run_case(0, 32'd1,          8'd0,  32'd1,      4,   3,   0,    0,  32'd1);
    run_case(0, 32'd100,        8'd0,  32'd5050,   202, 3,   0,    0,  32'd100);
    run_case(0, 32'h8000_0000,  8'd0,  32'd0,      2,   3,   0,    0,  32'h8000_0000);
    run_case(0, 32'd10,         8'd0,  32'd55,     22,  3,   0,    5,  32'd3);
    run_case(0, 32'd10,         8'd0,  32'd10,     10,  3,   8,    0,  32'd4);
    // 8-bit instance: 465 mod 256 = 209; 8128 mod 256 = 192 with n at max positive.
    run_case(1, 32'd0,          8'd30, 32'd209,    62,  3,   0,    0,  32'd0);
    run_case(1, 32'd0,          8'd127, 32'd192,   256, 3,   0,    0,  32'd0);
    run_case(1, 32'd0,          8'h80, 32'd0,      2,   3,   0,    0,  32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sum_accum.md
Name: sum_accum

Overview:
- HLS-style sequential datapath computing the C function `int sum(int n){ int s=0; for(int i=1;i<=n;i++) s+=i; return s; }`.
- Starts automatically on every release of reset, iterates one addition per two cycles, then holds the result on `return_val` until the next reset.
- Standalone top-level kernel with no start/ready handshake; the enclosing system resets it to launch a computation.

Parameters:
- DATA_W, 32, width of `n`, the accumulator and `return_val` (two's-complement signed).

Ports:
- sys_clk  input  1  rising-edge clock, sole clock domain.
- sys_rst_n  input  1  reset, synchronous and active-low.
- n  input  DATA_W  loop bound, signed; must be stable at the first rising edge after `sys_rst_n` goes high.
- return_val  output  DATA_W  final sum, registered.

Behaviour:
- Reset: one clock; reset is synchronous and active-low. A rising edge with `sys_rst_n`=0 sets:
  - state=INIT
  - return_val=0
  - acc=0
  - i=0
  - n_reg=0
- FSM states: INIT, CHECK, BODY, DONE.
- INIT (1 cycle): n_reg<=n, i<=1, acc<=0; next CHECK.
- CHECK: compare i <= n_reg as signed, sign-extended to DATA_W+1 bits so the loop always terminates.
  - True: next BODY.
  - False: return_val<=acc; next DONE.
- BODY: acc<=acc+i (mod 2^DATA_W, overflow silently wraps); i<=i+1 (DATA_W+1 bits internally); next CHECK.
- DONE: all registers hold; stays in DONE until reset. return_val never changes outside the CHECK->DONE transition and reset.
- Latency, counted in rising edges after the first edge sampling sys_rst_n=1:
  - n>=1: return_val is final after exactly 2n+2 edges (n=10 -> 22 edges).
  - n<=0: return_val is final after exactly 2 edges.
- `n` is sampled only in INIT; changes to `n` afterwards are ignored until the next reset.
- Reset asserted mid-computation aborts immediately and returns all state to reset values. Computation restarts on release.
- return_val reads 0 from reset until completion. Intermediate accumulator values are never exposed.

Optional Feature:
- Macro SUM_ACCUM_DONE_EN.
- Defined: adds output port `done` (1 bit), placed after return_val.
  - done=0 on reset.
  - done rises to 1 on the same edge return_val is loaded (CHECK->DONE) and stays 1 until reset.
- Undefined: no `done` port. All other behaviour is identical.

Decomposition:
- Package sum_accum_pkg holds:
  - DATA_W default constant.
  - State enum typedef {INIT, CHECK, BODY, DONE} (2-bit encoding).
- No sub-module: the FSM and a single adder/comparator fit in one module.

Test Plan:
- n=10, reset pulse low one edge, then release -> return_val=0 until edge 22 after release, then 55, held stable for 5000 time units.
- n=0 and n=-5 -> return_val=0 after 2 edges; done (if enabled) =1 at edge 2.
- n=1 -> 1 after 4 edges; n=100 -> 5050 after 202 edges.
- n=10, change n to 3 five edges after release -> result still 55.
- n=10, reassert reset at edge 8 after release, change n to 4, release -> return_val=0 during reset, then 10 after 10 edges.
- n=100000 -> wrapped result 705082704 (5000050000 mod 2^32), no hang; completes after 200002 edges.
